bsg_mem_1r1w_arb: RTL



---
 rtl/bsg_mem_1r1w_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/bsg_mem_1r1w_arb.sv
// Round-robin front end sharing one 1R1W async-read RAM among several clients.
// Define BSG_MEM_1R1W_ARB_BYPASS_EN to forward write data on same-address hazards instead of stalling the read.
module bsg_mem_1r1w_arb #(
  parameter int num_clients_p          = 4,
  parameter int width_p                = 32,
  parameter int els_p                  = 64,
  parameter bit read_write_same_addr_p = 1'b0,
  localparam int addr_width_lp         = $clog2(els_p),
  localparam int id_width_lp           = $clog2(num_clients_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_clients_p-1:0]               w_v_i,
  input  logic [num_clients_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_clients_p*width_p-1:0]       w_data_i,
  output logic [num_clients_p-1:0]               w_yumi_o,
  input  logic [num_clients_p-1:0]               r_v_i,
  input  logic [num_clients_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_clients_p-1:0]               r_yumi_o,
  output logic                                   r_data_v_o,
  output logic [width_p-1:0]                     r_data_o,
  output logic [id_width_lp-1:0]                 r_id_o,
  output logic                                   err_o,
  output logic                                   mem_w_v_o,
  output logic [addr_width_lp-1:0]               mem_w_addr_o,
  output logic [width_p-1:0]                     mem_w_data_o,
  output logic                                   mem_r_v_o,
  output logic [addr_width_lp-1:0]               mem_r_addr_o,
  input  logic [width_p-1:0]                     mem_r_data_i
);

`ifdef BSG_MEM_1R1W_ARB_BYPASS_EN
  localparam bit bypass_lp = 1'b1;
`else
  localparam bit bypass_lp = 1'b0;
`endif

  // Returns {found, index} of the first requester after ptr, wrapping.
  function automatic logic [id_width_lp:0] rr_pick(input logic [num_clients_p-1:0] req,
                                                   input logic [id_width_lp-1:0]   ptr);
    logic [id_width_lp:0] pick;
    pick = '0;
    for (int k = num_clients_p; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % num_clients_p;
      if (req[id_width_lp'(idx)]) pick = {1'b1, id_width_lp'(idx)};
    end
    return pick;
  endfunction

  logic [id_width_lp-1:0]   w_ptr, r_ptr;
  logic [id_width_lp-1:0]   w_idx, r_idx;
  logic                     w_found, r_found;
  logic                     w_grant, r_grant;
  logic                     w_in_range, r_in_range;
  logic                     hazard;
  logic [addr_width_lp-1:0] w_addr, r_addr;
  logic [width_p-1:0]       w_data;
  logic [width_p-1:0]       r_resp;

  assign {w_found, w_idx} = rr_pick(w_v_i, w_ptr);
  assign {r_found, r_idx} = rr_pick(r_v_i, r_ptr);

  assign w_addr = w_addr_i[w_idx*addr_width_lp +: addr_width_lp];
  assign w_data = w_data_i[w_idx*width_p +: width_p];
  assign r_addr = r_addr_i[r_idx*addr_width_lp +: addr_width_lp];

  assign w_in_range = int'(w_addr) < els_p;
  assign r_in_range = int'(r_addr) < els_p;

  // Grants are masked by reset so nothing is consumed while the block is held in reset.
  assign w_grant = reset_n_i & w_found;
  assign hazard  = !read_write_same_addr_p && w_grant && r_found && r_in_range
                   && (r_addr == w_addr);
  assign r_grant = reset_n_i & r_found & ~(hazard & ~bypass_lp);

  assign w_yumi_o = w_grant ? (num_clients_p'(1) << w_idx) : '0;
  assign r_yumi_o = r_grant ? (num_clients_p'(1) << r_idx) : '0;

  assign mem_w_v_o    = w_grant & w_in_range;
  assign mem_w_addr_o = w_addr;
  assign mem_w_data_o = w_data;
  assign mem_r_v_o    = r_grant & r_in_range & ~hazard;
  assign mem_r_addr_o = r_addr;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    r_resp = '0;
    if (hazard)          r_resp = w_data;
    else if (r_in_range) r_resp = mem_r_data_i;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_ptr      <= id_width_lp'(num_clients_p - 1);
      r_ptr      <= id_width_lp'(num_clients_p - 1);
      r_data_v_o <= 1'b0;
      r_data_o   <= '0;
      r_id_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      if (w_grant) w_ptr <= w_idx;
      if (r_grant) begin
        r_ptr    <= r_idx;
        r_data_o <= r_resp;
        r_id_o   <= r_idx;
      end
      r_data_v_o <= r_grant;
      if ((w_grant && !w_in_range) || (r_grant && !r_in_range)) err_o <= 1'b1;
    end
  end

endmodule
